fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
- REQ-001 RESET_IP, 16'h0000, instruction address loaded into ip at reset.
- REQ-002 TIMEOUT_CYCLES, 8'd255, REQ-state cycles without imem_ready before fetch_err; used only under FETCH_TIMEOUT_EN.
- REQ-003 One clock, clk; reset is rst_n, asynchronous, active-low.
- REQ-004 clk  in  1  rising-edge clock.
- REQ-005 rst_n  in  1  asynchronous active-low reset.
- REQ-006 next_ip  in  16  next instruction address from the branch/jump control stage.
- REQ-007 instr_ack  in  1  downstream has consumed instr; advance to next_ip.
- REQ-008 redirect  in  1  flush; restart fetch at redirect_addr.
- REQ-009 redirect_addr  in  16  restart address.
- REQ-010 imem_rdata  in  16  instruction memory read data.
- REQ-011 imem_ready  in  1  imem_rdata valid this cycle.
- REQ-012 imem_req  out  1  read request.
- REQ-013 imem_addr  out  16  read address, always equal to ip.
- REQ-014 ip  out  16  address of the current instruction, fed to the control stage.
- REQ-015 instr  out  16  fetched instruction word (opcode), fed to the control stage.
- REQ-016 instr_valid  out  1  instr and ip are valid.
- REQ-017 fetch_err  out  1  sticky fetch timeout flag.

Function
- REQ-018 The FSM SHALL have the states BOOT, REQ, HOLD and ERR, encoded as registered state.
- REQ-019 BOOT->REQ unconditionally on the first clock after reset release; in BOOT, imem_req=0.
- REQ-020 In REQ: imem_req=1 and imem_addr=ip; if imem_ready=1, then instr<=imem_rdata, instr_valid<=1, and ->HOLD.
- REQ-021 In HOLD: imem_req=0, and instr/ip are held stable; if instr_ack=1, then ip<=next_ip, instr_valid<=0, and ->REQ.
- REQ-022 instr_ack SHALL be ignored outside HOLD; imem_ready SHALL be ignored outside REQ.
- REQ-023 Latency: imem_ready in cycle N gives instr_valid=1 in N+1; instr_ack in cycle M gives imem_req=1 at ip=next_ip in M+1; best-case throughput is 1 instruction per 2 cycles.
- REQ-024 redirect=1 in any state other than BOOT: ip<=redirect_addr, instr_valid<=0, fetch_err<=0, ->REQ; it overrides instr_ack and imem_ready in the same cycle, and that cycle's rdata SHALL be discarded.
- REQ-025 ip arithmetic is 16-bit; next_ip and redirect_addr are taken verbatim, and 16'hFFFF->16'h0000 wraps with no flag.
- REQ-026 instr SHALL update only on a REQ-state imem_ready.

Reset
- REQ-027 rst_n low SHALL asynchronously force: state=BOOT, ip=RESET_IP, instr=16'h0000, instr_valid=0, fetch_err=0, timeout counter=0.
- REQ-028 Reset asserted mid-transaction SHALL abandon the pending read; a later imem_ready SHALL be ignored until REQ is re-entered.

Configuration
- REQ-029 With FETCH_TIMEOUT_EN defined, a counter SHALL clear on REQ entry and increment each REQ cycle without imem_ready; on reaching TIMEOUT_CYCLES the FSM goes ->ERR and fetch_err<=1.
- REQ-030 ERR SHALL hold imem_req=0 and instr_valid=0 until redirect or reset.
- REQ-031 Without FETCH_TIMEOUT_EN, there is no counter and no ERR state, fetch_err is tied 0, and REQ waits indefinitely.

Structure
- REQ-032 The shared package cpu_pkg SHALL hold WORD_W=16, the FSM state typedef, the RESET_IP default, and the opcode field constants (BR=4'b1100, JMP=4'b1101) shared with the control stage.
- REQ-033 The sub-module fetch_timeout_ctr SHALL contain the counter and compare, and be instantiated only under FETCH_TIMEOUT_EN.

Verification
- REQ-034 Reset release with RESET_IP=16'h0000 and imem_ready=1 on the 2nd clock, rdata=16'h1234 -> imem_req high one cycle after release, then instr=16'h1234 with instr_valid=1 at ip=16'h0000.
- REQ-035 In HOLD, instr_ack=1 with next_ip=16'h0005 -> next cycle imem_req=1, imem_addr=16'h0005, instr_valid=0.
- REQ-036 imem_ready delayed 3 cycles -> imem_req held high at a constant address for 4 cycles, then exactly one capture.
- REQ-037 redirect=1 with redirect_addr=16'h0040 in the same cycle as imem_ready with rdata=16'hDEAD -> rdata discarded, next imem_addr=16'h0040, instr unchanged.
- REQ-038 With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=4, hold imem_ready=0 -> fetch_err=1 after 4 REQ cycles with imem_req=0; a later redirect clears fetch_err and fetch restarts.
- REQ-039 rst_n pulsed low in HOLD with ip=16'h0010 -> immediately ip=RESET_IP, instr_valid=0, instr=16'h0000, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, fetch FSM states, reset vector and the
// opcode field values the control stage decodes.
package cpu_pkg;

    localparam int WORD_W = 16;

    localparam logic [WORD_W-1:0] RESET_IP = 16'h0000;

    localparam logic [3:0] OP_BR  = 4'b1100;
    localparam logic [3:0] OP_JMP = 4'b1101;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts REQ cycles that pass without imem_ready and flags the cycle in which
// the limit is reached. Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_timeout_ctr #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic timeout
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (clr) begin
            cnt <= 8'd0;
        end else if (inc) begin
            cnt <= cnt + 8'd1;
        end
    end

    // The limit-th idle cycle itself raises timeout, so the FSM leaves REQ
    // after exactly TIMEOUT_CYCLES idle cycles.
    assign timeout = inc && (cnt == TIMEOUT_CYCLES - 8'd1);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM (BOOT/REQ/HOLD/ERR) with one outstanding imem read.
// Optional read timeout with sticky fetch_err is enabled by FETCH_TIMEOUT_EN.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_IP_P = RESET_IP
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] next_ip,
    input  logic              instr_ack,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_addr,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              imem_ready,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    output logic [WORD_W-1:0] ip,
    output logic [WORD_W-1:0] instr,
    output logic              instr_valid,
    output logic              fetch_err
);

    fetch_state_t state, state_next;
    logic         timeout;
    logic         flush;
    logic         capture;

    // BOOT always proceeds to REQ, so a redirect there has no effect.
    assign flush    = redirect && (state != BOOT);
    assign capture  = (state == REQ) && imem_ready && !redirect;
    assign imem_req = (state == REQ);
    assign imem_addr = ip;

`ifdef FETCH_TIMEOUT_EN
    fetch_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    ((state != REQ) || redirect),
        .inc    ((state == REQ) && !imem_ready),
        .timeout(timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_err <= 1'b0;
        end else if (flush) begin
            fetch_err <= 1'b0;
        end else if ((state == REQ) && timeout) begin
            fetch_err <= 1'b1;
        end
    end
`else
    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT: state_next = REQ;
            REQ: begin
                if (redirect) begin
                    state_next = REQ;
                end else if (imem_ready) begin
                    state_next = HOLD;
                end else if (timeout) begin
                    state_next = ERR;
                end
            end
            HOLD: begin
                if (redirect || instr_ack) begin
                    state_next = REQ;
                end
            end
            ERR: begin
                if (redirect) begin
                    state_next = REQ;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    // instr_valid mirrors "in HOLD", registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ip          <= RESET_IP_P;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            instr_valid <= (state_next == HOLD);
            if (flush) begin
                ip <= redirect_addr;
            end else if ((state == HOLD) && instr_ack) begin
                ip <= next_ip;
            end
            if (capture) begin
                instr <= imem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; define FETCH_TIMEOUT_EN to
// also exercise the timeout/ERR path with a limit of 4 cycles.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] next_ip;
    logic        instr_ack;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] ip;
    logic [15:0] instr;
    logic        instr_valid;
    logic        fetch_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_IP_P(16'h0000)
`ifdef FETCH_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(8'd4)
`endif
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .next_ip      (next_ip),
        .instr_ack    (instr_ack),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .ip           (ip),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .fetch_err    (fetch_err)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        next_ip = 16'h0000;
        instr_ack = 1'b0;
        redirect = 1'b0;
        redirect_addr = 16'h0000;
        imem_rdata = 16'h0000;
        imem_ready = 1'b0;
        #3;
        check("rst_ip", ip, 16'h0000);
        check("rst_instr", instr, 16'h0000);
        check("rst_valid", {15'd0, instr_valid}, 16'd0);
        check("rst_req", {15'd0, imem_req}, 16'd0);
        check("rst_err", {15'd0, fetch_err}, 16'd0);

        tick();
        tick();
        rst_n = 1'b1;
        check("boot_req", {15'd0, imem_req}, 16'd0);

        // first fetch: ready on the 2nd clock after release
        tick();
        check("req1_req", {15'd0, imem_req}, 16'd1);
        check("req1_addr", imem_addr, 16'h0000);
        check("req1_valid", {15'd0, instr_valid}, 16'd0);
        imem_ready = 1'b1;
        imem_rdata = 16'h1234;
        tick();
        check("cap1_instr", instr, 16'h1234);
        check("cap1_valid", {15'd0, instr_valid}, 16'd1);
        check("cap1_ip", ip, 16'h0000);
        check("cap1_req", {15'd0, imem_req}, 16'd0);

        // imem_ready outside REQ is ignored
        imem_rdata = 16'hBEEF;
        tick();
        check("hold_instr", instr, 16'h1234);
        check("hold_valid", {15'd0, instr_valid}, 16'd1);
        imem_ready = 1'b0;

        instr_ack = 1'b1;
        next_ip = 16'h0005;
        tick();
        check("ack_req", {15'd0, imem_req}, 16'd1);
        check("ack_addr", imem_addr, 16'h0005);
        check("ack_valid", {15'd0, instr_valid}, 16'd0);

        // ready delayed 3 cycles; instr_ack outside HOLD must not move ip
        next_ip = 16'h0009;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_req", {15'd0, imem_req}, 16'd1);
            check("wait_addr", imem_addr, 16'h0005);
        end
        instr_ack = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 16'hA5A5;
        tick();
        check("cap2_instr", instr, 16'hA5A5);
        check("cap2_valid", {15'd0, instr_valid}, 16'd1);
        imem_rdata = 16'h5A5A;
        tick();
        check("cap2_once", instr, 16'hA5A5);
        imem_ready = 1'b0;

        // redirect coinciding with imem_ready discards the data
        instr_ack = 1'b1;
        next_ip = 16'h0020;
        tick();
        instr_ack = 1'b0;
        check("ack2_addr", imem_addr, 16'h0020);
        imem_ready = 1'b1;
        imem_rdata = 16'hDEAD;
        redirect = 1'b1;
        redirect_addr = 16'h0040;
        tick();
        redirect = 1'b0;
        check("redir_req", {15'd0, imem_req}, 16'd1);
        check("redir_addr", imem_addr, 16'h0040);
        check("redir_instr", instr, 16'hA5A5);
        check("redir_valid", {15'd0, instr_valid}, 16'd0);
        imem_rdata = 16'h0111;
        tick();
        imem_ready = 1'b0;
        check("cap3_instr", instr, 16'h0111);
        check("cap3_ip", ip, 16'h0040);

        // redirect in HOLD overrides instr_ack
        redirect = 1'b1;
        redirect_addr = 16'h0010;
        instr_ack = 1'b1;
        next_ip = 16'h0077;
        tick();
        redirect = 1'b0;
        instr_ack = 1'b0;
        check("hredir_addr", imem_addr, 16'h0010);
        check("hredir_valid", {15'd0, instr_valid}, 16'd0);
        imem_ready = 1'b1;
        imem_rdata = 16'h0C0D;
        tick();
        imem_ready = 1'b0;
        check("cap4_ip", ip, 16'h0010);
        check("cap4_valid", {15'd0, instr_valid}, 16'd1);

        // asynchronous reset in HOLD, no clock edge needed
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ip", ip, 16'h0000);
        check("arst_valid", {15'd0, instr_valid}, 16'd0);
        check("arst_instr", instr, 16'h0000);
        check("arst_req", {15'd0, imem_req}, 16'd0);
        imem_ready = 1'b1;
        imem_rdata = 16'h9999;
        #1;
        rst_n = 1'b1;
        tick();
        check("reboot_instr", instr, 16'h0000);
        check("reboot_valid", {15'd0, instr_valid}, 16'd0);
        check("reboot_req", {15'd0, imem_req}, 16'd1);
        tick();
        imem_ready = 1'b0;
        check("cap5_instr", instr, 16'h9999);

        // addresses are taken verbatim, including the FFFF -> 0000 wrap
        instr_ack = 1'b1;
        next_ip = 16'hFFFF;
        tick();
        instr_ack = 1'b0;
        check("wrap_hi", imem_addr, 16'hFFFF);
        imem_ready = 1'b1;
        imem_rdata = 16'h0001;
        tick();
        imem_ready = 1'b0;
        instr_ack = 1'b1;
        next_ip = 16'h0000;
        tick();
        instr_ack = 1'b0;
        check("wrap_lo", imem_addr, 16'h0000);

`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_wait_req", {15'd0, imem_req}, 16'd1);
            check("to_wait_err", {15'd0, fetch_err}, 16'd0);
        end
        tick();
        check("to_err", {15'd0, fetch_err}, 16'd1);
        check("to_req", {15'd0, imem_req}, 16'd0);
        check("to_valid", {15'd0, instr_valid}, 16'd0);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        check("err_sticky", {15'd0, fetch_err}, 16'd1);
        check("err_req", {15'd0, imem_req}, 16'd0);
        redirect = 1'b1;
        redirect_addr = 16'h0080;
        tick();
        redirect = 1'b0;
        check("err_clear", {15'd0, fetch_err}, 16'd0);
        check("err_restart", {15'd0, imem_req}, 16'd1);
        check("err_addr", imem_addr, 16'h0080);
        imem_ready = 1'b1;
        imem_rdata = 16'h4242;
        tick();
        imem_ready = 1'b0;
        check("err_cap", instr, 16'h4242);
`else
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        check("nto_req", {15'd0, imem_req}, 16'd1);
        check("nto_err", {15'd0, fetch_err}, 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
